uart_tx_flow_ctrl: RTL and testbench

UART_TX_FLOW_CTRL -- requirements
Module: uart_tx_flow_ctrl

---
 rtl/uart_tx_flow_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_flow_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_flow_ctrl.sv
// UART transmitter with RTS/CTS hardware flow control.
// A word is captured into a holding register with en, then tx_start raises RTS
// and waits (bounded by CTS_TIMEOUT) for CTS before sending
// start / DATA_W data bits LSB-first / optional parity / STOP_BITS stop bits.
// Optional feature macro: UART_TX_PARITY_EN (adds PARITY state and PARITY_ODD).
module uart_tx_flow_ctrl #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int CTS_TIMEOUT  = 1024
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_start,
  input  logic              CTS,
  output logic              RTS,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [2:0]        state
);

  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TCW = $clog2(CTS_TIMEOUT + 1);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [TCW-1:0] WAIT_LAST = TCW'(CTS_TIMEOUT - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    REQUEST = 3'd2,
    START   = 3'd3,
    DATA    = 3'd4,
`ifdef UART_TX_PARITY_EN
    PARITY  = 3'd5,
`endif
    STOP    = 3'd6
  } state_e;

  state_e            state_q;
  logic [BCW-1:0]    baud_q;     // cycles spent in the current bit
  logic [TCW-1:0]    wait_q;     // cycles spent waiting for CTS
  logic [3:0]        bit_q;      // data bit / stop bit index
  logic [DATA_W-1:0] hold_q;     // word captured by en
  logic [DATA_W-1:0] sh_q;       // shifter; bit 0 is on the line during DATA
  logic              timeout_q;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Frame sequencer: state, counters, holding register and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      wait_q    <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
      sh_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, READ: begin
          baud_q <= '0;
          bit_q  <= '0;
          wait_q <= '0;
          // A same-cycle en+tx_start captures the word and sends it
          if (en) hold_q <= data_in;
          if (tx_start)  state_q <= REQUEST;
          else if (en)   state_q <= READ;
          else           state_q <= IDLE;
        end
        REQUEST: begin
          if (CTS) begin
            state_q <= START;
            baud_q  <= '0;
            wait_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            wait_q    <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        // From here on CTS is ignored: a started frame always completes
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= hold_q;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            sh_q   <= sh_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            baud_q  <= '0;
            bit_q   <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              state_q <= IDLE;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          wait_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  // Serial line decoded purely from registered state
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:  tx = 1'b0;
      DATA:   tx = sh_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = (^hold_q) ^ PARITY_ODD;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign RTS     = (state_q >= REQUEST) && (state_q <= STOP);
  assign busy    = (state_q != IDLE) && (state_q != READ);
  assign done    = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_uart_tx_flow_ctrl.sv
// Self-checking bench for uart_tx_flow_ctrl: a vector table for the
// control-path corners, then frames checked cycle by cycle against an
// expected line waveform built from the frame format.
module tb_uart_tx_flow_ctrl;

  localparam int DW = 8, CPB = 4, SB = 1, TO = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam bit PODD = 1'b0;
  localparam int FB = 1 + DW + PB + SB;

  logic clk = 1'b0;
  logic rst, en, tx_start, CTS;
  logic [DW-1:0] data_in;
  logic RTS, tx, busy, done, timeout;
  logic [2:0] state;

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  uart_tx_flow_ctrl #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .CTS_TIMEOUT(TO)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(PODD)
`endif
  ) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .tx_start(tx_start),
    .CTS(CTS), .RTS(RTS), .tx(tx), .busy(busy), .done(done),
    .timeout(timeout), .state(state)
  );

  typedef struct {
    logic rst, en, ts, cts;
    logic [7:0] d;
    logic [2:0] st;
    logic rts, tx, bsy;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {state, RTS, tx, busy, done, timeout};
  endfunction

  function automatic logic [7:0] ev(input int st, input bit r, input bit t,
                                    input bit b, input bit dn, input bit o);
    return {3'(st), r, t, b, dn, o};
  endfunction

  // mode 0: en then tx_start; 1: en+tx_start together; 2: tx_start only (held word)
  // dly: cycles CTS stays low in REQUEST; poke: en/tx_start/FF mid-frame;
  // rnd_cts: toggle CTS during the frame; abort_k: frame cycle to hit rst (-1 none)
  task automatic send(input logic [7:0] d, input int mode, input int dly,
                      input bit poke, input bit rnd_cts, input int abort_k);
    logic [FB-1:0] bits;
    int done_n, busy_n, st_e, b;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    if (PB == 1) bits[1+DW] = (^d) ^ PODD;
    for (int s = 0; s < SB; s++) bits[1+DW+PB+s] = 1'b1;

    CTS = 1'b0;
    if (mode == 0) begin
      en = 1'b1; data_in = d;
      step;
      chk("load_read", 32'(state), 32'd1);
      en = 1'b0;
    end
    tx_start = 1'b1;
    if (mode == 1) begin en = 1'b1; data_in = d; end
    step;
    en = 1'b0; tx_start = 1'b0; data_in = 8'($urandom);
    chk("req_entry", 32'(obs()), 32'(ev(2, 1, 1, 1, 0, 0)));
    for (int j = 0; j < dly; j++) begin
      step;
      chk("req_wait", 32'(obs()), 32'(ev(2, 1, 1, 1, 0, 0)));
    end
    CTS = 1'b1;
    step;

    done_n = 0; busy_n = 0;
    for (int k = 0; k < FB*CPB; k++) begin
      b = k / CPB;
      if (b == 0)                    st_e = 3;
      else if (b <= DW)              st_e = 4;
      else if (PB == 1 && b == DW+1) st_e = 5;
      else                           st_e = 6;
      chk($sformatf("frame_%0h_k%0d", d, k), 32'(obs()),
          32'(ev(st_e, 1, bits[b], 1, (k == FB*CPB-1), 0)));
      busy_n += int'(busy);
      done_n += int'(done);
      if (k == abort_k) begin
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("rst_abort", 32'(obs()), 32'(ev(0, 0, 1, 0, 0, 0)));
        for (int j = 0; j < 6; j++) begin
          step;
          chk("post_abort", 32'(obs()), 32'(ev(0, 0, 1, 0, 0, 0)));
        end
        CTS = 1'b0;
        return;
      end
      if (rnd_cts) CTS = 1'($urandom);
      if (poke && k == 8) begin
        en = 1'b1; tx_start = 1'b1; data_in = 8'hFF;
      end else begin
        en = 1'b0; tx_start = 1'b0;
      end
      step;
    end
    chk("frame_end", 32'(obs()), 32'(ev(0, 0, 1, 0, 0, 0)));
    chk("busy_cycles", 32'(busy_n), 32'(FB*CPB));
    chk("done_count", 32'(done_n), 32'd1);
    CTS = 1'b0;
  endtask

  task automatic cts_timeout;
    int rts_n, to_n;
    rts_n = 0; to_n = 0;
    CTS = 1'b0; tx_start = 1'b1;
    step;
    tx_start = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      chk($sformatf("timeout_j%0d", j), 32'(obs()),
          32'(ev((j <= TO) ? 2 : 0, (j <= TO), 1, (j <= TO), 0, (j == TO+1))));
      rts_n += int'(RTS);
      to_n  += int'(timeout);
      step;
    end
    chk("timeout_rts_cycles", 32'(rts_n), 32'(TO));
    chk("timeout_pulses", 32'(to_n), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tx_start = 1'b0; CTS = 1'b0; data_in = '0;

    //           rst   en    ts    cts   d      st    rts   tx    bsy
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 3'd1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 3'd1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; tx_start = tbl[i].ts;
      CTS = tbl[i].cts; data_in = tbl[i].d;
      step;
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'(ev(tbl[i].st, tbl[i].rts, tbl[i].tx, tbl[i].bsy, 0, 0)));
    end
    rst = 1'b0; en = 1'b0; tx_start = 1'b0; CTS = 1'b0;

    send(8'h00, 2, 0, 1'b0, 1'b0, -1);   // holding register cleared by reset
    send(8'hA5, 0, 0, 1'b0, 1'b0, -1);
    cts_timeout();
    send(8'h3C, 1, 3, 1'b1, 1'b1, -1);   // same-cycle capture, ignored poke, CTS drop
    send(8'h3C, 2, 0, 1'b0, 1'b0, -1);   // word still held after the poke
    send(8'h5A, 0, 0, 1'b0, 1'b0, 4*CPB+1); // reset during data bit 3
    send(8'h07, 0, 0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 8; r++)
      send(8'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
           1'($urandom), 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
